// File: rtl/echo_adc_capture_if.sv
// echo_adc_capture_if: FSMC-side read strobe interface for the capture buffer
interface echo_adc_capture_if #(parameter int ADC_W = 12) ();
  logic             rd_en;
  logic [ADC_W:0]   rd_data;
  logic             rd_valid;
  modport master (output rd_en, input rd_data, rd_valid);
  modport slave  (input rd_en, output rd_data, rd_valid);
endinterface

// File: rtl/echo_adc_capture.sv
// echo_adc_capture: trigger-delayed, decimated ADC record capture with strobe readout
module echo_adc_capture #(
  parameter int ADC_W = 12,
  parameter int AW    = 10
) (
  input  logic              clk_80mhz,
  input  logic              rst_n,
  input  logic              trig,
  input  logic [15:0]       cfg_delay,
  input  logic [AW:0]       cfg_len,
  input  logic [3:0]        cfg_decim,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_ovr,
  echo_adc_capture_if.slave rd,
  output logic              busy,
  output logic              done,
  output logic              ovr_flag,
  output logic              trig_lost
);
  typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, READY} state_t;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};
  state_t         state_q;
  logic [15:0]    dly_q;
  logic [3:0]     decim_q, dc_q;
  logic [AW:0]    len_q, wcnt_q, rcnt_q, len_d;
  logic [ADC_W:0] mem [2**AW];
  logic [ADC_W:0] rd_data_q;
  logic           rd_valid_q, ovr_q, lost_q, wr_d, rd_d, last_rd_d;
  always_comb begin
    len_d     = (cfg_len == '0 || cfg_len > DEPTH) ? DEPTH : cfg_len;
    wr_d      = state_q == CAPTURE && dc_q == 4'd0;
    rd_d      = state_q == READY && rd.rd_en;
    last_rd_d = rd_d && rcnt_q == len_q - ONE;
  end
  always_ff @(posedge clk_80mhz)
    if (wr_d) mem[wcnt_q[AW-1:0]] <= {adc_ovr, adc_data};
  always_ff @(posedge clk_80mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dly_q      <= '0;
      decim_q    <= '0;
      dc_q       <= '0;
      len_q      <= '0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_d;
      if (rd_d) rd_data_q <= mem[rcnt_q[AW-1:0]];
      if (trig && state_q != IDLE) lost_q <= 1'b1;
      case (state_q)
        IDLE: if (trig) begin
          dly_q   <= cfg_delay;
          decim_q <= cfg_decim;
          len_q   <= len_d;
          dc_q    <= '0;
          wcnt_q  <= '0;
          rcnt_q  <= '0;
          ovr_q   <= 1'b0;
          lost_q  <= 1'b0;
          state_q <= cfg_delay == 16'd0 ? CAPTURE : DELAY;
        end
        DELAY: begin
          dly_q <= dly_q - 16'd1;
          if (dly_q == 16'd1) state_q <= CAPTURE;
        end
        CAPTURE: begin
          // dc_q counts skipped samples down to the next stored one
          dc_q <= wr_d ? decim_q : dc_q - 4'd1;
          if (wr_d) begin
            wcnt_q <= wcnt_q + ONE;
            ovr_q  <= ovr_q | adc_ovr;
            if (wcnt_q + ONE == len_q) state_q <= READY;
          end
        end
        READY: if (rd_d) begin
          rcnt_q <= rcnt_q + ONE;
          if (last_rd_d) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rd.rd_data  = rd_data_q;
  assign rd.rd_valid = rd_valid_q;
  assign busy        = state_q == DELAY || state_q == CAPTURE;
  assign done        = state_q == READY;
  assign ovr_flag    = ovr_q;
  assign trig_lost   = lost_q;
endmodule

// File: doc/echo_adc_capture.md
# echo_adc_capture

Receive-side companion to the EMA pulse generator. Takes the one-cycle burst-start strobe issued at the first transmit edge, waits a programmable delay, and captures a programmable number of ADC samples (optionally decimated) into an on-chip buffer. It then presents the record to the FSMC-side reader through a simple read-strobe interface. The block sits between the ADC parallel bus and the FSMC read path, in the 80 MHz domain.

## Interface
- ADC_W, 12, ADC sample width
- AW, 10, buffer address width; depth = 2^AW samples
- clk_80mhz  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- trig  in  1  one-cycle burst-start strobe, synchronous to clk_80mhz
- cfg_delay  in  16  cycles from trigger to first sample; latched on accepted trig
- cfg_len  in  AW+1  samples per record; 0 or >2^AW means 2^AW; latched on accepted trig
- cfg_decim  in  4  store every (cfg_decim+1)-th sample; latched on accepted trig
- adc_data  in  ADC_W  ADC sample, sampled every clock
- adc_ovr  in  1  ADC over-range flag, aligned with adc_data
- rd_en  in  1  read strobe from FSMC side
- rd_data  out  ADC_W+1  {per-sample ovr, sample}
- rd_valid  out  1  rd_data valid this cycle
- busy  out  1  delay or capture in progress
- done  out  1  record complete, readable
- ovr_flag  out  1  sticky: any over-range in current record
- trig_lost  out  1  sticky: trigger arrived while not IDLE

## Operation
- States: IDLE, DELAY, CAPTURE, READY.
- IDLE: trig=1 → latch cfg_*, clear ovr_flag and trig_lost, zero wr_addr/rd_addr/sample count, go DELAY. If cfg_delay=0, go directly to CAPTURE.
- DELAY: 16-bit down-counter loaded with cfg_delay; at terminal count go CAPTURE.
- CAPTURE: write {adc_ovr, adc_data} to buffer[wr_addr] on the first CAPTURE cycle, then every (cfg_decim+1) cycles. Increment wr_addr per write. ovr_flag |= adc_ovr on written samples only. After the cfg_len-th write, go READY.
- READY: done=1. rd_en=1 → rd_data = buffer[rd_addr] next cycle with rd_valid=1, then rd_addr+1. The read returning sample cfg_len-1 moves to IDLE; done drops in the same cycle that rd_valid is high for the last word.
- rd_en outside READY: ignored, rd_valid stays 0, rd_addr unchanged.
- trig in DELAY/CAPTURE/READY: ignored, trig_lost=1 (held until next accepted trig). A READY record is never overwritten.
- trig in the cycle the last read completes: ignored, trig_lost=1. A trigger is accepted only in IDLE.
- Sample count width AW+1. Effective length = 2^AW when cfg_len=0 or cfg_len>2^AW.
- Reset mid-operation: return to IDLE immediately. Buffer contents are not cleared and are undefined to the reader.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=0, done=0, ovr_flag=0, trig_lost=0; state IDLE.
- trig high at edge T, D=cfg_delay, k=cfg_decim+1, L=effective length.
- Sample n (0..L-1) is the adc_data/adc_ovr value present at edge T+1+D+n·k.
- busy=1 from cycle T+1 through the cycle of the last write.
- done=1 from the cycle after the last write.
- Read latency 1: rd_en at edge R → rd_valid=1 and rd_data valid after edge R+1. Back-to-back rd_en gives one word per cycle.
- rd_valid is a single-cycle pulse per accepted rd_en.
- Minimum trigger-to-trigger spacing = 1+D+(L-1)·k+1+L cycles with continuous reads.

## Test plan
- Basic: cfg_delay=5, cfg_len=8, cfg_decim=0, adc_data=counter value at each edge, trig at edge 100 → buffer holds 106..113; done rises at edge 114; 8 reads return 106..113 with rd_valid, and done falls on the 8th rd_valid.
- Decimation and zero delay: cfg_delay=0, cfg_len=4, cfg_decim=2, trig at edge 50 → samples from edges 51, 54, 57, 60; busy is high for cycles 51–60.
- Over-range and length wrap: cfg_len=0 → 1024 samples captured. adc_ovr=1 at only the 3rd written sample → ovr_flag=1, rd_data[ADC_W]=1 on word 2 only. A second record without ovr clears ovr_flag on its trig.
- Lost trigger: trig during DELAY and again during READY → trig_lost=1, and the record read back is unchanged. Next trig in IDLE clears trig_lost.
- Read gating: rd_en pulses during IDLE/CAPTURE → no rd_valid. Gapped rd_en in READY (every 3rd cycle) → words returned in order with no skips.
- Reset mid-capture: rst_n low at sample 3 of 8 → all outputs go to 0 asynchronously, state IDLE. A new trig after release captures a full record correctly.
